// File: rtl/upsample_window_buf.sv
// Tile buffer and 2x2 edge-replicated window sequencer for the bilinear upsampler.
// Define UPSAMPLE_WIN_PINGPONG_EN for two tile banks and bubble-free back-to-back tiles.
module upsample_window_buf #(
  parameter int DATA_W = 12,
  parameter int TILE_W = 4,
  parameter int TILE_H = 4,
  localparam int XW = (TILE_W > 2) ? $clog2(TILE_W) : 1,
  localparam int YW = (TILE_H > 2) ? $clog2(TILE_H) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [DATA_W*TILE_W*TILE_H-1:0] load_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [DATA_W-1:0]               win_p00,
  output logic [DATA_W-1:0]               win_p01,
  output logic [DATA_W-1:0]               win_p10,
  output logic [DATA_W-1:0]               win_p11,
  output logic [XW-1:0]                   win_x,
  output logic [YW-1:0]                   win_y,
  output logic                            win_last
);

  localparam int NPIX = TILE_W * TILE_H;
  localparam int IW   = $clog2(NPIX) + 1;

  typedef logic [NPIX-1:0][DATA_W-1:0] tile_t;
  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_adv, x1;
  logic [YW-1:0] y_q, y_d, y_adv, y1;
  logic          x_end, y_end;
  tile_t         load_pix, rd_tile;
  logic [IW-1:0] row0, row1;
  logic [IW-2:0] a00, a01, a10, a11;

  assign load_pix = load_data;
  assign x_end    = (x_q == XW'(TILE_W - 1));
  assign y_end    = (y_q == YW'(TILE_H - 1));
  assign win_last = x_end && y_end;
  assign win_x    = x_q;
  assign win_y    = y_q;

  // Raster advance; the final window wraps back to (0,0) ready for the next tile.
  always_comb begin
    x_adv = x_end ? '0 : x_q + XW'(1);
    y_adv = y_q;
    if (x_end) y_adv = y_end ? '0 : y_q + YW'(1);
  end

  // Neighbour indices clamp at the right/bottom edge instead of wrapping.
  always_comb begin
    x1   = x_end ? x_q : x_q + XW'(1);
    y1   = y_end ? y_q : y_q + YW'(1);
    row0 = IW'(y_q) * IW'(TILE_W);
    row1 = IW'(y1) * IW'(TILE_W);
    a00  = (IW-1)'(row0 + IW'(x_q));
    a01  = (IW-1)'(row0 + IW'(x1));
    a10  = (IW-1)'(row1 + IW'(x_q));
    a11  = (IW-1)'(row1 + IW'(x1));
  end

  assign win_p00 = rd_tile[a00];
  assign win_p01 = rd_tile[a01];
  assign win_p10 = rd_tile[a10];
  assign win_p11 = rd_tile[a11];

`ifdef UPSAMPLE_WIN_PINGPONG_EN
  tile_t [1:0] tile_q, tile_d;
  logic  [1:0] full_q, full_d;
  logic        cur_q, cur_d, tgt;

  assign rd_tile = tile_q[cur_q];

  // Invariant: the shadow bank is only ever full while the scan bank is full.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    tile_d     = tile_q;
    full_d     = full_q;
    cur_d      = cur_q;
    load_ready = !full_q[~cur_q];
    win_valid  = (state_q == SCAN);
    tgt        = full_q[cur_q] ? ~cur_q : cur_q;
    if (load_valid && load_ready) begin
      tile_d[tgt] = load_pix;
      full_d[tgt] = 1'b1;
      if (!full_q[cur_q]) begin
        x_d = '0;
        y_d = '0;
      end
    end
    if (win_valid && win_ready) begin
      x_d = x_adv;
      y_d = y_adv;
      if (win_last) begin
        full_d[cur_q] = 1'b0;
        if (full_d[~cur_q]) cur_d = ~cur_q;
      end
    end
    state_d = full_d[cur_d] ? SCAN : IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_q <= '0;
      full_q <= '0;
      cur_q  <= 1'b0;
    end else begin
      tile_q <= tile_d;
      full_q <= full_d;
      cur_q  <= cur_d;
    end
  end
`else
  tile_t tile_q, tile_d;

  assign rd_tile = tile_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    tile_d     = tile_q;
    load_ready = 1'b0;
    win_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          tile_d  = load_pix;
          x_d     = '0;
          y_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        win_valid = 1'b1;
        if (win_ready) begin
          x_d = x_adv;
          y_d = y_adv;
          if (win_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tile_q <= '0;
    else      tile_q <= tile_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_upsample_window_buf.sv
// Directed bench for upsample_window_buf: 4x4 tile, pixel (r,c) = base + r*4 + c.
module tb_upsample_window_buf;
  localparam int DW = 12;
  localparam int TW = 4;
  localparam int TH = 4;
  localparam int NP = TW * TH;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid, load_ready;
  logic [DW*NP-1:0] load_data;
  logic          win_valid, win_ready, win_last;
  logic [DW-1:0] win_p00, win_p01, win_p10, win_p11;
  logic [1:0]    win_x, win_y;

  always #5 clk = ~clk;

  upsample_window_buf #(.DATA_W(DW), .TILE_W(TW), .TILE_H(TH)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_p00(win_p00), .win_p01(win_p01), .win_p10(win_p10), .win_p11(win_p11),
    .win_x(win_x), .win_y(win_y), .win_last(win_last)
  );

  typedef struct {
    int x, y, p00, p01, p10, p11;
    bit last;
  } win_t;

  win_t tbl[16];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] wpack(input int x, input int y, input int a, input int b,
                                        input int c, input int d, input bit l);
    return {11'd0, 2'(x), 2'(y), 12'(a), 12'(b), 12'(c), 12'(d), l};
  endfunction

  function automatic logic [DW*NP-1:0] mk_tile(input int base);
    logic [DW*NP-1:0] t;
    t = '0;
    for (int i = 0; i < NP; i++) t[DW*i +: DW] = DW'(base + i);
    return t;
  endfunction

  // Called at a negedge with load_ready=1; returns at the negedge after capture.
  task automatic load_tile(input int base);
    load_data  = mk_tile(base);
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // mode 0: win_ready always 1; mode 1: win_ready 1,0,1,0...
  task automatic scan(input int n_win, input int off0, input int off1, input int mode,
                      output int hs, output int cyc, output bit lr_seen);
    win_t e;
    int   o;
    bit   rdy, drop;
    hs = 0; cyc = 0; lr_seen = 1'b0;
    while (hs < n_win && cyc < 100) begin
      chk($sformatf("valid_c%0d", cyc), win_valid, 1);
      e = tbl[hs % 16];
      o = (hs < 16) ? off0 : off1;
      chk($sformatf("win%0d_c%0d", hs, cyc),
          wpack(win_x, win_y, win_p00, win_p01, win_p10, win_p11, win_last),
          wpack(e.x, e.y, e.p00 + o, e.p01 + o, e.p10 + o, e.p11 + o, e.last));
      if (win_valid && load_ready) lr_seen = 1'b1;
      rdy       = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      win_ready = rdy;
      drop      = load_valid && load_ready;
      if (win_valid && rdy) hs++;
      cyc++;
      @(negedge clk);
      if (drop) load_valid = 1'b0;
    end
    win_ready = 1'b0;
  endtask

  initial begin
    int hs, cyc;
    bit lr;
    tbl[0]  = '{0, 0,  0,  1,  4,  5, 0};
    tbl[1]  = '{1, 0,  1,  2,  5,  6, 0};
    tbl[2]  = '{2, 0,  2,  3,  6,  7, 0};
    tbl[3]  = '{3, 0,  3,  3,  7,  7, 0};
    tbl[4]  = '{0, 1,  4,  5,  8,  9, 0};
    tbl[5]  = '{1, 1,  5,  6,  9, 10, 0};
    tbl[6]  = '{2, 1,  6,  7, 10, 11, 0};
    tbl[7]  = '{3, 1,  7,  7, 11, 11, 0};
    tbl[8]  = '{0, 2,  8,  9, 12, 13, 0};
    tbl[9]  = '{1, 2,  9, 10, 13, 14, 0};
    tbl[10] = '{2, 2, 10, 11, 14, 15, 0};
    tbl[11] = '{3, 2, 11, 11, 15, 15, 0};
    tbl[12] = '{0, 3, 12, 13, 12, 13, 0};
    tbl[13] = '{1, 3, 13, 14, 13, 14, 0};
    tbl[14] = '{2, 3, 14, 15, 14, 15, 0};
    tbl[15] = '{3, 3, 15, 15, 15, 15, 1};

    rst = 1'b0; load_valid = 1'b0; win_ready = 1'b0; load_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", win_valid, 0);
    chk("rst_pix", {win_p00, win_p01, win_p10, win_p11}, 0);
    chk("rst_xy_last", {win_x, win_y, win_last}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_load_ready", load_ready, 1);
    chk("rel_valid", win_valid, 0);

    // Unstalled scan of tile A
    load_tile(0);
    scan(16, 0, 0, 0, hs, cyc, lr);
    chk("a_hs", hs, 16);
    chk("a_cycles", cyc, 16);
    chk("a_end_valid", win_valid, 0);
    chk("a_end_load_ready", load_ready, 1);

    // Alternating backpressure: same sequence, windows held through stalls
    load_tile(0);
    scan(16, 0, 0, 1, hs, cyc, lr);
    chk("t_hs", hs, 16);
    chk("t_cycles", cyc, 31);
    chk("t_end_valid", win_valid, 0);

    // Tile A accepted, then tile B offered continuously during A's scan
    load_data  = mk_tile(0);
    load_valid = 1'b1;
    @(negedge clk);
    load_data  = mk_tile(100);
`ifdef UPSAMPLE_WIN_PINGPONG_EN
    scan(32, 0, 100, 0, hs, cyc, lr);
    chk("pp_shadow_ready", lr, 1);
    chk("pp_hs", hs, 32);
    chk("pp_cycles", cyc, 32);
    chk("pp_end_valid", win_valid, 0);
`else
    scan(16, 0, 0, 0, hs, cyc, lr);
    chk("c_ready_low_in_scan", lr, 0);
    chk("c_hs", hs, 16);
    chk("c_end_load_ready", load_ready, 1);
    chk("c_end_valid", win_valid, 0);
    @(negedge clk);
    load_valid = 1'b0;
    scan(16, 100, 100, 0, hs, cyc, lr);
    chk("c_b_hs", hs, 16);
    chk("c_b_cycles", cyc, 16);
`endif

    // Reset while window 7 is presented
    load_tile(0);
    scan(7, 0, 0, 0, hs, cyc, lr);
    chk("pre_rst_win",
        wpack(win_x, win_y, win_p00, win_p01, win_p10, win_p11, win_last),
        wpack(3, 1, 7, 7, 11, 11, 0));
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", win_valid, 0);
    chk("mid_rst_pix", {win_p00, win_p01, win_p10, win_p11}, 0);
    chk("mid_rst_xy", {win_x, win_y, win_last}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_load_ready", load_ready, 1);
    chk("post_rst_valid", win_valid, 0);
    load_tile(100);
    scan(16, 100, 100, 0, hs, cyc, lr);
    chk("r_hs", hs, 16);
    chk("r_end_valid", win_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
